// File: rtl/riscv_pkg.sv
// riscv_pkg: shared definitions for the RV32I core front end.
//   XLEN             - architectural register / address width
//   RESET_PC_DEFAULT - default first fetch address after reset
//   NOP_INSTR        - canonical NOP (addi x0, x0, 0) used by decode on bubbles
//   fetch_entry_t    - {pc, instr} pair held in the fetch queue
//   align_word()     - clears address bits [1:0]
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO of {pc, instr} entries for the fetch stage.
//   clk, rst_n - clock, async active-low reset
//   flush      - synchronous clear of all entries (wins over wr_en/rd_en)
//   wr_en      - push wr_data (ignored when full)
//   wr_data    - entry to push
//   rd_en      - pop head entry (ignored when empty)
//   rd_data    - head entry (undefined contents when empty)
//   count      - number of valid entries
//   empty/full - occupancy flags
module fetch_queue
  import riscv_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         wr_en,
  input  fetch_entry_t wr_data,
  input  logic         rd_en,
  output fetch_entry_t rd_data,
  output logic [CW-1:0] count,
  output logic         empty,
  output logic         full
);

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_wr;
  logic            do_rd;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign do_wr = wr_en && !full && !flush;
  assign do_rd = rd_en && !empty && !flush;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      if (do_wr && !do_rd)      count <= count + CW'(1);
      else if (!do_wr && do_rd) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: RV32I fetch stage. Issues in-order word reads,
// buffers returned words with their PCs and hands them to decode.
//   clk, rst_n          - clock, async active-low reset
//   imem_req_valid/ready - request handshake, imem_req_addr = fetch address
//   imem_rsp_valid/data  - one in-order response per accepted request
//   redirect_valid/pc    - taken branch / jump from execute; squashes younger work
//   if_valid/ready       - decode handshake, if_instr/if_pc = queue head
//
// state | meaning
// ------+------------------------------------------------------------
// BOOT  | one cycle after reset release, no requests issued
// RUN   | normal fetching under the credit rule
module instruction_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
);

  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW+1)'(QUEUE_DEPTH);

  typedef enum logic {BOOT, RUN} state_t;

  state_t        state_q;
  state_t        state_d;
  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [31:0]   redirect_pc_w;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW:0]   credit_used;
  logic          req_fire;
  logic          q_wr;
  logic          q_rd;
  logic          q_empty;
  logic          q_full;
  logic [CW-1:0] q_count;
  fetch_entry_t  q_wr_data;
  fetch_entry_t  q_rd_data;

  assign redirect_pc_w = align_word(redirect_pc);

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= BOOT;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  // FSM: outputs. Outstanding requests plus buffered words never exceed the
  // queue depth, so every response is guaranteed a free slot.
  assign credit_used = {1'b0, outstanding} + {1'b0, q_count};

  always_comb begin
    imem_req_valid = 1'b0;
    if (state_q == RUN)
      imem_req_valid = !redirect_valid && (credit_used < DEPTH_W);
  end

  assign req_fire      = imem_req_valid && imem_req_ready;
  assign imem_req_addr = fetch_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              fetch_pc <= RESET_PC;
    else if (redirect_valid) fetch_pc <= redirect_pc_w;
    else if (req_fire)       fetch_pc <= fetch_pc + 32'd4;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
    end else begin
      case ({req_fire, imem_rsp_valid})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Everything still in flight at a redirect is stale; a response landing in
  // the redirect cycle itself is discarded directly, hence the subtraction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      drop_cnt <= '0;
    else if (redirect_valid)
      drop_cnt <= outstanding - CW'(imem_rsp_valid);
    else if (imem_rsp_valid && (drop_cnt != '0))
      drop_cnt <= drop_cnt - CW'(1);
  end

  assign q_wr = imem_rsp_valid && !redirect_valid && (drop_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              resp_pc <= RESET_PC;
    else if (redirect_valid) resp_pc <= redirect_pc_w;
    else if (q_wr)           resp_pc <= resp_pc + 32'd4;
  end

  assign q_wr_data = '{pc: resp_pc, instr: imem_rsp_data};
  assign q_rd      = if_valid && if_ready;

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (redirect_valid),
    .wr_en   (q_wr),
    .wr_data (q_wr_data),
    .rd_en   (q_rd),
    .rd_data (q_rd_data),
    .count   (q_count),
    .empty   (q_empty),
    .full    (q_full)
  );

  // Decode sees nothing during a redirect; the head may be a squashed word.
  assign if_valid = !q_empty && !redirect_valid;
  assign if_instr = if_valid ? q_rd_data.instr : '0;
  assign if_pc    = if_valid ? q_rd_data.pc    : '0;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  instruction_fetch_unit #(
    .RESET_PC    (32'h0000_0000),
    .QUEUE_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0050_0093;
      32'h0000_0004: return 32'h00a0_0113;
      default:       return a ^ 32'h1357_9BDF;
    endcase
  endfunction

  // Memory model: fixed latency, in-order responses.
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t       mq[$];
  logic [31:0] acc_log[$];
  int          lat = 1;

  initial forever begin
    @(negedge clk);
    if (rst_n && imem_req_valid && imem_req_ready) begin
      mq.push_back('{imem_req_addr, cyc + lat});
      acc_log.push_back(imem_req_addr);
    end
  end

  initial begin
    mreq_t r;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      imem_rsp_valid = 1'b0;
      if (rst_n && mq.size() > 0 && mq[0].due <= cyc) begin
        r = mq.pop_front();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(r.addr);
      end
    end
  end

  // Scoreboard of the instruction stream decode must see.
  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
  exp_t sb[$];
  int   consumed = 0;

  task automatic sb_load(input logic [31:0] start, input int n);
    logic [31:0] pc;
    sb.delete();
    consumed = 0;
    pc = start;
    for (int i = 0; i < n; i++) begin
      sb.push_back('{pc, mem_word(pc)});
      pc = pc + 32'd4;
    end
  endtask

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst_n && if_valid && if_ready) begin
      checks++;
      assert (sb.size() > 0) else begin
        failures++;
        $error("FAIL sb_underflow observed_pc=%h expected=no_transfer", if_pc);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        consumed++;
        chk("sb_pc", if_pc, e.pc);
        chk("sb_instr", if_instr, e.instr);
      end
    end
    if (rst_n && dut.q_wr) begin
      checks++;
      assert (!dut.q_full) else begin
        failures++;
        $error("FAIL queue_write_when_full observed=1 expected=0");
      end
    end
  end

  task automatic drive_pt();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) drive_pt();
  endtask

  // Asserts reset at a negedge, checks async reset values, releases reset in
  // the following drive slot; on return the bench is in BOOT cycle 1.
  task automatic apply_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    mq.delete();
    acc_log.delete();
    imem_rsp_valid = 1'b0;
    chk({tag, "_rst_req_valid"}, 32'(imem_req_valid), 32'd0);
    chk({tag, "_rst_req_addr"}, imem_req_addr, 32'h0);
    chk({tag, "_rst_if_valid"}, 32'(if_valid), 32'd0);
    chk({tag, "_rst_if_instr"}, if_instr, 32'h0);
    chk({tag, "_rst_if_pc"}, if_pc, 32'h0);
    chk({tag, "_rst_outstanding"}, 32'(dut.outstanding), 32'd0);
    chk({tag, "_rst_drop_cnt"}, 32'(dut.drop_cnt), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_if_valid(input string tag, input int maxc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < maxc && !seen; i++) begin
      @(negedge clk);
      if (if_valid) seen = 1'b1;
    end
    checks++;
    assert (seen) else begin
      failures++;
      $error("FAIL %s_timeout observed=no_if_valid expected=if_valid within %0d cycles", tag, maxc);
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    imem_req_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if_ready       = 1'b1;

    // Phase 1: basic stream, L=1
    lat = 1; if_ready = 1'b1;
    sb_load(32'h0, 40);
    apply_reset("p1");
    @(negedge clk);
    chk("p1_c1_req_valid", 32'(imem_req_valid), 32'd0);
    @(negedge clk);
    chk("p1_c2_req_valid", 32'(imem_req_valid), 32'd1);
    chk("p1_c2_req_addr", imem_req_addr, 32'h0);
    @(negedge clk);
    chk("p1_c3_req_addr", imem_req_addr, 32'h4);
    chk("p1_c3_if_valid", 32'(if_valid), 32'd0);
    @(negedge clk);
    chk("p1_c4_if_valid", 32'(if_valid), 32'd1);
    chk("p1_c4_if_pc", if_pc, 32'h0);
    chk("p1_c4_if_instr", if_instr, 32'h0050_0093);
    @(negedge clk);
    chk("p1_c5_if_pc", if_pc, 32'h4);
    chk("p1_c5_if_instr", if_instr, 32'h00a0_0113);
    run(20);
    chk("p1_consumed", 32'(consumed >= 10), 32'd1);

    // Phase 2: decode stalled, credits limit requests to the queue depth
    lat = 1; if_ready = 1'b0;
    sb_load(32'h0, 40);
    apply_reset("p2");
    run(10);
    @(negedge clk);
    chk("p2_req_count", 32'(acc_log.size()), 32'd2);
    chk("p2_req0_addr", acc_log[0], 32'h0);
    chk("p2_req1_addr", acc_log[1], 32'h4);
    chk("p2_req_valid_held", 32'(imem_req_valid), 32'd0);
    chk("p2_if_pc_full", if_pc, 32'h0);
    drive_pt();
    if_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("p2_release_if_valid", 32'(if_valid), 32'd1);
    chk("p2_release_if_pc", if_pc, 32'h4);
    run(20);
    chk("p2_consumed", 32'(consumed >= 10), 32'd1);

    // Phase 2b: redirect with a full queue and decode ready; no transfer allowed
    lat = 1; if_ready = 1'b0;
    sb_load(32'h0, 40);
    apply_reset("p2b");
    run(8);
    if_ready       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0300;
    sb_load(32'h300, 40);
    @(negedge clk);
    chk("p2b_redir_if_valid", 32'(if_valid), 32'd0);
    chk("p2b_redir_req_valid", 32'(imem_req_valid), 32'd0);
    drive_pt();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("p2b_post_if_valid", 32'(if_valid), 32'd0);
    chk("p2b_post_req_valid", 32'(imem_req_valid), 32'd1);
    chk("p2b_post_req_addr", imem_req_addr, 32'h300);
    run(10);
    chk("p2b_consumed", 32'(consumed >= 3), 32'd1);

    // Phase 3: L=3, redirect with two requests outstanding
    lat = 3; if_ready = 1'b1;
    sb_load(32'h0, 40);
    apply_reset("p3");
    run(3);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    sb_load(32'h100, 40);
    @(negedge clk);
    chk("p3_outstanding_reqs", 32'(acc_log.size()), 32'd2);
    chk("p3_redir_req_valid", 32'(imem_req_valid), 32'd0);
    drive_pt();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("p3_drop_cnt", 32'(dut.drop_cnt), 32'd2);
    chk("p3_c5_req_valid", 32'(imem_req_valid), 32'd0);
    @(negedge clk);
    chk("p3_c6_req_valid", 32'(imem_req_valid), 32'd1);
    chk("p3_c6_req_addr", imem_req_addr, 32'h100);
    wait_if_valid("p3", 20);
    chk("p3_first_if_pc", if_pc, 32'h100);
    run(12);
    chk("p3_consumed", 32'(consumed >= 2), 32'd1);

    // Phase 4: L=2, redirect in the same cycle as a response
    lat = 2; if_ready = 1'b1;
    sb_load(32'h0, 40);
    apply_reset("p4");
    run(3);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    sb_load(32'h200, 40);
    @(negedge clk);
    chk("p4_rsp_in_redirect", 32'(imem_rsp_valid), 32'd1);
    chk("p4_redir_if_valid", 32'(if_valid), 32'd0);
    chk("p4_redir_req_valid", 32'(imem_req_valid), 32'd0);
    drive_pt();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("p4_drop_cnt", 32'(dut.drop_cnt), 32'd1);
    chk("p4_post_req_addr", imem_req_addr, 32'h200);
    wait_if_valid("p4", 20);
    chk("p4_first_if_pc", if_pc, 32'h200);
    chk("p4_first_if_instr", if_instr, mem_word(32'h200));
    run(10);

    // Phase 5: misaligned redirect near the top of the address space
    lat = 1; if_ready = 1'b1;
    sb_load(32'h0, 40);
    apply_reset("p5");
    run(2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    sb_load(32'hFFFF_FFFC, 40);
    acc_log.delete();
    drive_pt();
    redirect_valid = 1'b0;
    run(10);
    @(negedge clk);
    chk("p5_req0_addr", acc_log[0], 32'hFFFF_FFFC);
    chk("p5_req1_addr", acc_log[1], 32'h0000_0000);
    chk("p5_consumed", 32'(consumed >= 3), 32'd1);

    // Phase 6: reset mid-stream with the queue full
    lat = 1; if_ready = 1'b0;
    sb_load(32'h0, 40);
    apply_reset("p6a");
    run(8);
    @(negedge clk);
    chk("p6_full_if_valid", 32'(if_valid), 32'd1);
    sb_load(32'h0, 40);
    apply_reset("p6b");
    @(negedge clk);
    chk("p6_boot_req_valid", 32'(imem_req_valid), 32'd0);
    @(negedge clk);
    chk("p6_c2_req_valid", 32'(imem_req_valid), 32'd1);
    chk("p6_c2_req_addr", imem_req_addr, 32'h0);
    drive_pt();
    if_ready = 1'b1;
    run(15);
    chk("p6_consumed", 32'(consumed >= 6), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
